led_walk_arbiter: RTL and testbench
===================================

LED_WALK_ARBITER -- requirements
Module: led_walk_arbiter

Interface
REQ-001 Parameter NUM_LEDS, default 8: walk length in LEDs; SHALL be >= 2.
REQ-002 Parameter NUM_REQ, default 4: number of requesters sharing the LED bank; SHALL be >= 2.
REQ-003 Parameter STEP_CYCLES, default 4: clock cycles each LED is held lit; SHALL be >= 1.
REQ-004 Clocking SHALL be as follows: one clock; reset is asynchronous and active-low.
REQ-005 i_clk  input  1  sole clock, all state on rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_req  input  NUM_REQ  level request per requester; held high until o_done or abort.
REQ-008 o_grant  output  NUM_REQ  one-hot current owner, all-zero when no owner.
REQ-009 o_owner  output  clog2(NUM_REQ)  index of current owner, 0 when no owner.
REQ-010 o_leds  output  NUM_LEDS  one-hot walking LED, all-zero outside WALK.
REQ-011 o_done  output  NUM_REQ  one-cycle pulse on bit of requester whose walk completed.
REQ-012 o_busy  output  1  high in WALK and DONE.

Function
REQ-013 FSM states SHALL be IDLE, WALK, DONE; all outputs SHALL be registered.
REQ-014 IDLE: if any i_req bit high at edge t, arbiter SHALL pick a winner and at t+1 enter WALK with o_grant/o_owner set, o_leds = bit 0 set, step counter = 0.
REQ-015 Arbitration SHALL be round-robin: search starts at index (last_owner+1) mod NUM_REQ, last_owner = NUM_REQ-1 after reset so requester 0 wins first.
REQ-016 WALK: LED position p SHALL be held exactly STEP_CYCLES cycles, then advance to p+1; total walk = NUM_LEDS*STEP_CYCLES cycles.
REQ-017 After LED NUM_LEDS-1 held STEP_CYCLES cycles, FSM SHALL enter DONE for exactly one cycle: o_leds = 0, o_grant = 0, o_done bit of owner = 1, o_busy = 1.
REQ-018 DONE SHALL always go to IDLE; IDLE SHALL last at least one cycle before the next grant (no back-to-back walk).
REQ-019 Abort: if owner's i_req is low at any edge in WALK, FSM SHALL go to IDLE next cycle with o_leds, o_grant, o_done all zero; last_owner SHALL update to the aborted owner.
REQ-020 Requests from non-owners during WALK/DONE SHALL be ignored, not latched; arbitration uses only i_req sampled in IDLE.
REQ-021 Step counter SHALL be clog2(STEP_CYCLES+1) bits wide and LED index clog2(NUM_LEDS) bits wide, with no wrap past NUM_LEDS-1.
REQ-022 o_done SHALL never be high for more than one cycle per walk and never in the same cycle as nonzero o_leds.

Reset
REQ-023 While i_rst_n low, SHALL force state IDLE, o_grant = 0, o_owner = 0, o_leds = 0, o_done = 0, o_busy = 0, counters = 0, last_owner = NUM_REQ-1.
REQ-024 Reset assertion mid-WALK SHALL clear o_leds asynchronously; after release the first grant SHALL follow REQ-014/REQ-015 as from power-up.

Structure
REQ-025 Package led_walk_pkg SHALL hold the FSM state encoding (IDLE, WALK, DONE) and a clog2-based width helper constant set.
REQ-026 Round-robin winner selection SHALL be a combinational sub-module rr_arbiter (inputs: request vector, last_owner; outputs: one-hot grant, index, valid).
REQ-027 Parameter legality (REQ-001..003) SHALL be checked at elaboration.

Verification (NUM_LEDS=8, NUM_REQ=4, STEP_CYCLES=4)
REQ-028 i_req=0001 at cycle 0 -> o_grant=0001 cycle 1, o_leds=0x01 cycles 1-4, 0x02 cycles 5-8, ..., 0x80 cycles 29-32, o_done=0001 cycle 33, o_busy low cycle 34.
REQ-029 i_req=0101 held -> requester 0 walks first, then requester 2 granted at cycle 35; then requester 0 again.
REQ-030 i_req=1111 held for 4 walks -> grant order 0,1,2,3, each exactly 32 LED cycles, o_done pulses in same order.
REQ-031 i_req=0010, drop bit 1 at cycle 10 -> cycle 11 o_leds=0, o_grant=0, o_done=0; next walk with i_req=0011 grants requester 0 before 1 only if search from index 2 wraps (grant requester 0).
REQ-032 Assert i_rst_n low at cycle 15 of a walk -> o_leds=0 immediately; after release with i_req=1000 -> requester 3 granted one cycle after first sampled edge.
REQ-033 Assertions: o_grant one-hot-or-zero, o_leds one-hot-or-zero, o_leds nonzero implies o_busy, o_done single-cycle.

Source files
------------

// File: rtl/led_walk_pkg.sv
// -----------------------------------------------------------------------------
// led_walk_pkg
// Shared definitions for the LED walk arbiter:
//   state_t  - controller FSM encoding (IDLE, WALK, DONE)
//   clog2_w  - width helper that never returns less than one bit, so counter
//              and index widths stay legal even for degenerate parameters
// No ports (package).
// -----------------------------------------------------------------------------
package led_walk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2_w(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/led_walk_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin winner selection. The search starts one past the
// previous owner and wraps, so the previous owner has the lowest priority.
// Ports:
//   i_req    [NUM_REQ]  request vector
//   i_last   [IDX_W]    index of the previous owner
//   o_grant  [NUM_REQ]  one-hot winner, zero when no request
//   o_idx    [IDX_W]    index of the winner, zero when no request
//   o_valid             at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    int w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        // Offset NUM_REQ lands back on the previous owner, giving it last pick.
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand = int'(i_last) + off;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!o_valid && i_req[IDX_W'(w_cand)]) begin
                o_valid                 = 1'b1;
                o_idx                   = IDX_W'(w_cand);
                o_grant[IDX_W'(w_cand)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_walk_arbiter.sv
// -----------------------------------------------------------------------------
// led_walk_arbiter
// Shares one LED bank between NUM_REQ requesters. A granted requester gets a
// single walk of a lit LED from bit 0 to bit NUM_LEDS-1, each LED held for
// STEP_CYCLES clocks, followed by a one-cycle completion pulse. Dropping the
// request mid-walk aborts it. Ownership rotates round-robin.
// Ports:
//   i_clk    sole clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_req    [NUM_REQ]          level request per requester
//   o_grant  [NUM_REQ]          one-hot current owner, zero when none
//   o_owner  [clog2(NUM_REQ)]   index of current owner, zero when none
//   o_leds   [NUM_LEDS]         one-hot walking LED, zero outside the walk
//   o_done   [NUM_REQ]          one-cycle pulse for the owner whose walk ended
//   o_busy                      high while walking or signalling completion
// -----------------------------------------------------------------------------
module led_walk_arbiter
    import led_walk_pkg::*;
#(
    parameter int NUM_LEDS    = 8,
    parameter int NUM_REQ     = 4,
    parameter int STEP_CYCLES = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_REQ-1:0]          i_req,
    output logic [NUM_REQ-1:0]          o_grant,
    output logic [clog2_w(NUM_REQ)-1:0] o_owner,
    output logic [NUM_LEDS-1:0]         o_leds,
    output logic [NUM_REQ-1:0]          o_done,
    output logic                        o_busy
);

    localparam int OWN_W = clog2_w(NUM_REQ);
    localparam int LED_W = clog2_w(NUM_LEDS);
    localparam int CNT_W = clog2_w(STEP_CYCLES + 1);

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [LED_W-1:0] LED_LAST  = LED_W'(NUM_LEDS - 1);
    localparam logic [OWN_W-1:0] OWN_RESET = OWN_W'(NUM_REQ - 1);

    if (NUM_LEDS < 2) begin : g_bad_num_leds
        $error("led_walk_arbiter: NUM_LEDS must be >= 2");
    end
    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("led_walk_arbiter: NUM_REQ must be >= 2");
    end
    if (STEP_CYCLES < 1) begin : g_bad_step_cycles
        $error("led_walk_arbiter: STEP_CYCLES must be >= 1");
    end

    state_t             r_state;
    logic [CNT_W-1:0]   r_step;
    logic [LED_W-1:0]   r_led_idx;
    logic [OWN_W-1:0]   r_last_owner;

    logic [NUM_REQ-1:0] w_arb_grant;
    logic [OWN_W-1:0]   w_arb_idx;
    logic               w_arb_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWN_W)
    ) u_rr_arbiter (
        .i_req   (i_req),
        .i_last  (r_last_owner),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_step       <= '0;
            r_led_idx    <= '0;
            r_last_owner <= OWN_RESET;
            o_grant      <= '0;
            o_owner      <= '0;
            o_leds       <= '0;
            o_done       <= '0;
            o_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    o_done <= '0;
                    if (w_arb_valid) begin
                        r_state      <= ST_WALK;
                        // Recording the winner now is equivalent to recording
                        // it at completion/abort: no arbitration happens until
                        // this walk has ended.
                        r_last_owner <= w_arb_idx;
                        o_grant      <= w_arb_grant;
                        o_owner      <= w_arb_idx;
                        o_leds       <= NUM_LEDS'(1);
                        o_busy       <= 1'b1;
                        r_step       <= '0;
                        r_led_idx    <= '0;
                    end
                end

                ST_WALK: begin
                    if (!i_req[o_owner]) begin
                        // Owner withdrew: abort straight to IDLE, no done pulse.
                        r_state   <= ST_IDLE;
                        o_grant   <= '0;
                        o_owner   <= '0;
                        o_leds    <= '0;
                        o_busy    <= 1'b0;
                        r_step    <= '0;
                        r_led_idx <= '0;
                    end else if (r_step == STEP_LAST) begin
                        r_step <= '0;
                        if (r_led_idx == LED_LAST) begin
                            r_state   <= ST_DONE;
                            o_done    <= o_grant;
                            o_grant   <= '0;
                            o_owner   <= '0;
                            o_leds    <= '0;
                            r_led_idx <= '0;
                        end else begin
                            r_led_idx <= r_led_idx + LED_W'(1);
                            o_leds    <= {o_leds[NUM_LEDS-2:0], 1'b0};
                        end
                    end else begin
                        r_step <= r_step + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    o_done  <= '0;
                    o_busy  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    o_grant <= '0;
                    o_owner <= '0;
                    o_leds  <= '0;
                    o_done  <= '0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    a_grant_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_grant));
    a_leds_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_leds));
    a_leds_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (|o_leds) |-> o_busy);
    a_done_single: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (|o_done) |=> (o_done == '0));
    a_done_no_leds: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (|o_done) |-> (o_leds == '0));

endmodule

// File: tb/tb_led_walk_arbiter.sv
module tb_led_walk_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic [7:0] leds;
    logic [3:0] done;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    led_walk_arbiter #(
        .NUM_LEDS    (8),
        .NUM_REQ     (4),
        .STEP_CYCLES (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (req),
        .o_grant (grant),
        .o_owner (owner),
        .o_leds  (leds),
        .o_done  (done),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Reset with all requests low; leaves reset released mid-cycle so the
    // next rising edge is edge 0 of a test.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        req   = 4'b0000;
        steps(2);
        check({tag, "_rst_grant"}, 32'(grant), 32'h0);
        check({tag, "_rst_owner"}, 32'(owner), 32'h0);
        check({tag, "_rst_leds"},  32'(leds),  32'h0);
        check({tag, "_rst_done"},  32'(done),  32'h0);
        check({tag, "_rst_busy"},  32'(busy),  32'h0);
        rst_n = 1'b1;
    endtask

    // Called in the first cycle of a walk. Checks all 32 walk cycles, the
    // DONE cycle and the following IDLE cycle; returns in that IDLE cycle.
    task automatic walk_check(input string tag, input int own);
        check({tag, "_owner"}, 32'(owner), 32'(own));
        check({tag, "_busy"},  32'(busy),  32'h1);
        for (int c = 0; c < 32; c++) begin
            check({tag, "_leds"},  32'(leds),  32'(8'h01 << (c / 4)));
            check({tag, "_grant"}, 32'(grant), 32'(4'b0001 << own));
            step();
        end
        check({tag, "_done_leds"},  32'(leds),  32'h0);
        check({tag, "_done_grant"}, 32'(grant), 32'h0);
        check({tag, "_done_pulse"}, 32'(done),  32'(4'b0001 << own));
        check({tag, "_done_busy"},  32'(busy),  32'h1);
        step();
        check({tag, "_idle_done"},  32'(done),  32'h0);
        check({tag, "_idle_busy"},  32'(busy),  32'h0);
        check({tag, "_idle_grant"}, 32'(grant), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;

        // Single requester, full walk timing.
        do_reset("single");
        req = 4'b0001;
        step();
        walk_check("single", 0);
        req = 4'b0000;
        step();
        check("single_stay_idle_grant", 32'(grant), 32'h0);
        check("single_stay_idle_busy",  32'(busy),  32'h0);

        // Two requesters held: 0, then 2 at cycle 35, then 0 again.
        do_reset("pair");
        req = 4'b0101;
        step();
        walk_check("pair_w0", 0);
        step();
        walk_check("pair_w2", 2);
        step();
        check("pair_w3_grant", 32'(grant), 32'h1);
        check("pair_w3_owner", 32'(owner), 32'h0);
        req = 4'b0000;
        step();
        check("pair_abort_leds", 32'(leds), 32'h0);

        // All four held: strict rotation 0,1,2,3.
        do_reset("all");
        req = 4'b1111;
        step();
        walk_check("all_w0", 0);
        step();
        walk_check("all_w1", 1);
        step();
        walk_check("all_w2", 2);
        step();
        walk_check("all_w3", 3);
        req = 4'b0000;
        step();

        // Abort: requester 1 drops its request sampled at edge 10.
        do_reset("abort");
        req = 4'b0010;
        step();
        check("abort_grant", 32'(grant), 32'h2);
        check("abort_owner", 32'(owner), 32'h1);
        steps(9);
        check("abort_c10_leds", 32'(leds), 32'h04);
        req = 4'b0000;
        step();
        check("abort_c11_leds",  32'(leds),  32'h0);
        check("abort_c11_grant", 32'(grant), 32'h0);
        check("abort_c11_done",  32'(done),  32'h0);
        check("abort_c11_busy",  32'(busy),  32'h0);
        // Search starts at 2 and wraps, so requester 0 beats requester 1.
        req = 4'b0011;
        step();
        check("abort_next_grant", 32'(grant), 32'h1);
        check("abort_next_owner", 32'(owner), 32'h0);
        check("abort_next_leds",  32'(leds),  32'h01);
        req = 4'b0000;
        step();

        // Reset asserted mid-walk clears outputs without a clock edge.
        do_reset("midrst");
        req = 4'b0001;
        step();
        steps(14);
        check("midrst_c15_leds", 32'(leds), 32'h08);
        rst_n = 1'b0;
        #1;
        check("midrst_async_leds",  32'(leds),  32'h0);
        check("midrst_async_grant", 32'(grant), 32'h0);
        check("midrst_async_busy",  32'(busy),  32'h0);
        req = 4'b1000;
        steps(2);
        rst_n = 1'b1;
        check("midrst_held_grant", 32'(grant), 32'h0);
        step();
        check("midrst_after_grant", 32'(grant), 32'h8);
        check("midrst_after_owner", 32'(owner), 32'h3);
        check("midrst_after_leds",  32'(leds),  32'h01);
        req = 4'b0000;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
